// File: rtl/aes_top.sv
// ---------------------------------------------------------------------------
// aes_top -- iterative AES-128 encryption core, one round per clock.
//
// The core runs continuously: every 11 cycles it samples the plaintext and
// key (LOAD), runs ten rounds with on-the-fly key expansion, and refreshes
// the registered ciphertext output on the tenth round.
//
// Ports:
//   clk    in   1    system clock, rising edge
//   rst    in   1    synchronous active-high reset
//   state  in   128  plaintext, bits [127:120] = byte 0 (column-major)
//   key    in   128  cipher key, same byte ordering
//   out    out  128  ciphertext, registered, same byte ordering
//   done   out  1    one-cycle pulse with each out update
//                    (present only when AES_DONE_EN is defined)
//
// Optional feature macro: AES_DONE_EN
// ---------------------------------------------------------------------------
module aes_top (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] state,
  input  logic [127:0] key,
  output logic [127:0] out
`ifdef AES_DONE_EN
  ,
  output logic         done
`endif
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [3:0]   r_rc;
  logic [127:0] r_state;
  logic [127:0] r_roundKey;
  logic [127:0] r_out;

  logic [7:0]   w_subBytes [16];
  logic [7:0]   w_shifted  [16];
  logic [7:0]   w_mixed    [16];
  logic [127:0] w_shiftedFlat;
  logic [127:0] w_mixedFlat;
  logic [7:0]   w_rcon;
  logic [31:0]  w_rotWord;
  logic [31:0]  w_subWord;
  logic [31:0]  w_w0, w_w1, w_w2, w_w3;
  logic [127:0] w_rkNext;

  // Byte g of the state sits at bits [127-8g -: 8]; the column-major layout
  // means byte g is row g%4 of column g/4. ShiftRows moves row r left by r,
  // so output (r,c) takes input (r,(c+r)%4).
  genvar g;
  for (g = 0; g < 16; g++) begin : gSubShift
    localparam int Src = (g % 4) + 4 * (((g / 4) + (g % 4)) % 4);
    assign w_subBytes[g] = SBOX[r_state[127-8*g -: 8]];
    assign w_shifted[g]  = w_subBytes[Src];
    assign w_shiftedFlat[127-8*g -: 8] = w_shifted[g];
    assign w_mixedFlat[127-8*g -: 8]   = w_mixed[g];
  end

  // 3*b is written as xtime(b)^b; each column row uses {02 03 01 01} rotated.
  for (g = 0; g < 4; g++) begin : gMix
    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    assign w_a0 = w_shifted[4*g];
    assign w_a1 = w_shifted[4*g+1];
    assign w_a2 = w_shifted[4*g+2];
    assign w_a3 = w_shifted[4*g+3];
    assign w_mixed[4*g]   = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
    assign w_mixed[4*g+1] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
    assign w_mixed[4*g+2] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
    assign w_mixed[4*g+3] = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
  end

  // Round constant for the key schedule step taken in the current round.
  always_comb begin
    w_rcon = 8'h00;
    case (r_rc)
      4'd1:    w_rcon = 8'h01;
      4'd2:    w_rcon = 8'h02;
      4'd3:    w_rcon = 8'h04;
      4'd4:    w_rcon = 8'h08;
      4'd5:    w_rcon = 8'h10;
      4'd6:    w_rcon = 8'h20;
      4'd7:    w_rcon = 8'h40;
      4'd8:    w_rcon = 8'h80;
      4'd9:    w_rcon = 8'h1b;
      4'd10:   w_rcon = 8'h36;
      default: w_rcon = 8'h00;
    endcase
  end

  // Next round key: w3 rotated one byte left, substituted, and mixed with
  // Rcon in its top byte, then chained through the four words.
  assign w_rotWord = {r_roundKey[23:0], r_roundKey[31:24]};
  assign w_subWord = {SBOX[w_rotWord[31:24]], SBOX[w_rotWord[23:16]],
                      SBOX[w_rotWord[15:8]],  SBOX[w_rotWord[7:0]]};
  assign w_w0      = r_roundKey[127:96] ^ w_subWord ^ {w_rcon, 24'h000000};
  assign w_w1      = r_roundKey[95:64] ^ w_w0;
  assign w_w2      = r_roundKey[63:32] ^ w_w1;
  assign w_w3      = r_roundKey[31:0]  ^ w_w2;
  assign w_rkNext  = {w_w0, w_w1, w_w2, w_w3};

`ifdef AES_DONE_EN
  logic r_done;
  assign done = r_done;
`endif

  // Round sequencer: LOAD at rc=0, full rounds at 1..9, and the final
  // round (no MixColumns) writes the output at rc=10 and wraps to LOAD.
  // Inputs are only looked at on the LOAD cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rc       <= 4'd0;
      r_state    <= '0;
      r_roundKey <= '0;
      r_out      <= '0;
`ifdef AES_DONE_EN
      r_done     <= 1'b0;
`endif
    end else begin
`ifdef AES_DONE_EN
      r_done <= (r_rc == 4'd10);
`endif
      if (r_rc == 4'd0) begin
        r_state    <= state ^ key;
        r_roundKey <= key;
        r_rc       <= 4'd1;
      end else if (r_rc == 4'd10) begin
        r_out      <= w_shiftedFlat ^ w_rkNext;
        r_rc       <= 4'd0;
      end else begin
        r_state    <= w_mixedFlat ^ w_rkNext;
        r_roundKey <= w_rkNext;
        r_rc       <= r_rc + 4'd1;
      end
    end
  end

  assign out = r_out;

endmodule

// File: tb/tb_aes_top.sv
// ---------------------------------------------------------------------------
// tb_aes_top -- scoreboard bench for aes_top using the FIPS-197 vectors.
// A reference phase counter decides when the core samples its inputs and
// when it must refresh its output; expected ciphertexts are queued at the
// sample point and popped by the monitor when the output update is due.
// ---------------------------------------------------------------------------
module tb_aes_top;

  localparam logic [127:0] KeyB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PtB   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CtB   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KeyC1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PtC1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CtC1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CtZ   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] state;
  logic [127:0] key;
  logic [127:0] out;
`ifdef AES_DONE_EN
  logic         done;
`endif

  int           vectors     = 0;
  int           miscompares = 0;
  int           timeouts    = 0;
  int           timeoutsSeen = 0;
  int           modelRc     = 0;
  logic [127:0] expQ [$];
  logic [127:0] heldExp     = '0;
  logic         doneExp     = 1'b0;

  always #5 clk = ~clk;

  aes_top dut (
    .clk   (clk),
    .rst   (rst),
    .state (state),
    .key   (key),
    .out   (out)
`ifdef AES_DONE_EN
    ,
    .done  (done)
`endif
  );

  // Known plaintext/key pairs and their ciphertexts; anything else yields X
  // so that an unexpected sample can never compare equal.
  function automatic logic [127:0] lookupCipher(input logic [127:0] pt, input logic [127:0] k);
    if (pt == PtB && k == KeyB)   return CtB;
    if (pt == PtC1 && k == KeyC1) return CtC1;
    if (pt == '0 && k == '0)      return CtZ;
    return 'x;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: at each falling edge check what the last rising edge produced,
  // then predict what the coming rising edge will do from the inputs now
  // present (inputs only change shortly after a rising edge).
  always @(negedge clk) begin
    checkOutput("out", out, heldExp);
`ifdef AES_DONE_EN
    checkOutput("done", {127'd0, done}, {127'd0, doneExp});
`endif
    if (timeouts != timeoutsSeen) begin
      checkOutput("roundWait", 128'(timeouts), 128'(timeoutsSeen));
      timeoutsSeen = timeouts;
    end
    doneExp = 1'b0;
    if (rst) begin
      expQ.delete();
      heldExp = '0;
      modelRc = 0;
    end else if (modelRc == 0) begin
      expQ.push_back(lookupCipher(state, key));
      modelRc = 1;
    end else if (modelRc == 10) begin
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL scoreboard: update due but queue empty at %0t", $time);
      end else begin
        heldExp = expQ.pop_front();
      end
      doneExp = 1'b1;
      modelRc = 0;
    end else begin
      modelRc++;
    end
  end

  task automatic applyStimulus(input logic [127:0] pt, input logic [127:0] k, input int cycles);
    state = pt;
    key   = k;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Wait until the core is in the given round; gives up after 15 cycles.
  task automatic waitForRound(input int target);
    int n;
    n = 0;
    while (modelRc != target && n < 15) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (modelRc != target) timeouts++;
  endtask

  initial begin
    $display("[TB] starting aes_top bench");
    rst   = 1'b1;
    state = PtB;
    key   = KeyB;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    applyStimulus(PtB, KeyB, 24);
    applyStimulus(PtC1, KeyC1, 24);
    applyStimulus('0, '0, 24);
    applyStimulus(PtB, KeyB, 24);

    // Change inputs in the middle of a computation.
    waitForRound(5);
    applyStimulus(PtC1, KeyC1, 24);

    // Reset in the middle of a computation, then restart.
    applyStimulus(PtB, KeyB, 3);
    waitForRound(7);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(PtB, KeyB, 24);

    @(negedge clk);
    #1;
    if (timeouts != timeoutsSeen) begin
      $display("[TB] FAIL roundWait: %0d waits expired", timeouts - timeoutsSeen);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aes_top.md
Name: aes_top

Overview:
- Iterative AES-128 encryption core: 128-bit plaintext and 128-bit cipher key in, 128-bit ciphertext out.
- Computes one round per clock with on-the-fly key expansion.
- Free-running: no start/valid handshake. It repeatedly samples its inputs and refreshes the registered output.
- Sits as a leaf crypto datapath under a system wrapper that holds inputs stable for many cycles.

Parameters:
- None. Key size fixed at 128 bits, 10 rounds.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- state  input  128  plaintext block; bits [127:120] = byte 0 (FIPS-197 column-major order).
- key  input  128  cipher key, same byte ordering.
- out  output  128  ciphertext, registered, same byte ordering.

Behaviour:
- Reset (rst=1 at posedge):
  - out <= 0, round counter <= 0, internal state and round-key registers <= 0.
  - Reset dominates all other activity, including mid-encryption; the next operation starts cleanly from LOAD.
- Round counter rc, 4 bits, values 0..10:
  - rc=0 (LOAD): state_reg <= state ^ key; rk_reg <= key; rc <= 1.
  - rc=1..9: rk_next = expand(rk_reg, rcon[rc]); state_reg <= MixColumns(ShiftRows(SubBytes(state_reg))) ^ rk_next; rk_reg <= rk_next; rc <= rc+1.
  - rc=10: final round without MixColumns; out <= ShiftRows(SubBytes(state_reg)) ^ rk_next; rc <= 0.
- Timing:
  - Period is 11 cycles.
  - out changes only on rc=10 cycles and holds between updates.
  - Latency from input sample (LOAD edge) to out update: 10 cycles.
  - After any input change, out is correct within 22 cycles.
  - Input changes during rounds 1..10 do not affect the current computation; they are picked up at the next LOAD.
- Key expansion per FIPS-197:
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ Rcon; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - Rcon sequence 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10.
- S-box: 16 instances for SubBytes plus 4 for SubWord, all combinational. Either table or GF(2^8) inverse + affine form; must match FIPS-197 exactly.
- MixColumns:
  - xtime(b) = {b[6:0],0} ^ (b[7] ? 8'h1b : 0).
  - Column matrix rows {02 03 01 01} rotated.
- Single datapath; no pipelining across blocks.

Optional Feature:
- Macro AES_DONE_EN.
- Defined:
  - Extra output port done (1 bit), registered.
  - done is high for exactly one cycle, coinciding with each out update (cycle after rc=10 edge).
  - done resets to 0.
- Undefined: no done port; behaviour otherwise identical.

Test Plan:
- Reset: hold rst=1 for 3 cycles with nonzero inputs -> out=0 throughout; after release, first out update exactly 11 cycles later.
- FIPS-197 C.1: key=000102030405060708090a0b0c0d0e0f, state=00112233445566778899aabbccddeeff -> out=69c4e0d86a7b0430d8cdb78070b4c55a within 22 cycles, stable while inputs held.
- FIPS-197 B: key=2b7e151628aed2a6abf7158809cf4f3c, state=3243f6a8885a308d313198a2e0370734 -> out=3925841d02dc09fbdc118597196a0b32.
- All-zero key and state -> out=66e94bd4ef8a2c3b884cfa59ca342b2e; verifies Rcon/S-box of zero path.
- Input change mid-round: switch from vector B to C.1 at rc=5 -> next update still B result; following update equals C.1 result.
- Mid-operation reset at rc=7 -> out=0 next cycle; encryption restarts with LOAD after rst deasserts; with AES_DONE_EN, done pulses once per 11 cycles and never during reset.
